// File: rtl/vx_dispatch_route_pkg.sv
// Shared GPU types used by the dispatch router: instruction payload layout,
// execution-type field width and performance counter width.
`ifndef NUM_EX_UNITS
`define NUM_EX_UNITS 4
`endif

package VX_gpu_pkg;

  localparam int EX_BITS       = 3;
  localparam int UUID_BITS     = 12;
  localparam int PERF_CTR_BITS = 16;

  typedef struct packed {
    logic [EX_BITS-1:0]   ex_type;
    logic [UUID_BITS-1:0] uuid;
    logic [31:0]          pc;
  } instr_data_t;

endpackage

// File: rtl/vx_dispatch_route_fifo.sv
// Per-unit instruction buffer: DEPTH entries, circular pointers that wrap
// naturally at DEPTH (power of two), registered full/empty and head.
module VX_dispatch_fifo #(
  parameter int DATAW = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [DATAW-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; push+pop together leaves count unchanged.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; cleared asynchronously so buffered entries are discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage, not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vx_dispatch_route.sv
// Dispatch router: steers each operand-collector instruction into the buffer
// of its execution unit (by ex_type), counts input stall cycles and flags
// instructions whose ex_type addresses no unit (those are dropped).
`ifndef NUM_EX_UNITS
`define NUM_EX_UNITS 4
`endif

module vx_dispatch_route
  import VX_gpu_pkg::*;
#(
  parameter int NUM_EX_UNITS = `NUM_EX_UNITS,
  parameter int DEPTH        = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      in_valid,
  input  logic [$bits(instr_data_t)-1:0]            in_data,
  output logic                                      in_ready,
  output logic [NUM_EX_UNITS-1:0]                   out_valid,
  output logic [NUM_EX_UNITS*$bits(instr_data_t)-1:0] out_data,
  input  logic [NUM_EX_UNITS-1:0]                   out_ready,
  output logic [PERF_CTR_BITS-1:0]                  perf_stalls,
  output logic                                      route_err
);

  localparam int DATAW = $bits(instr_data_t);

  instr_data_t               in_instr;
  logic                      route_ok;
  logic                      addr_full;
  logic                      fire;
  logic [NUM_EX_UNITS-1:0]   push;
  logic [NUM_EX_UNITS-1:0]   pop;
  logic [NUM_EX_UNITS-1:0]   unit_full;
  logic [NUM_EX_UNITS-1:0]   unit_empty;
  logic [PERF_CTR_BITS-1:0]  perf_stalls_q, perf_stalls_d;
  logic                      route_err_q, route_err_d;

  // Routing decode: only the addressed buffer's registered full gates input.
  always_comb begin
    in_instr  = in_data;
    route_ok  = 1'b0;
    addr_full = 1'b0;
    push      = '0;
    for (int unsigned i = 0; i < NUM_EX_UNITS; i++) begin
      if (in_instr.ex_type == EX_BITS'(i)) begin
        route_ok  = 1'b1;
        addr_full = unit_full[i];
      end
    end
    in_ready = !(route_ok && addr_full);
    fire     = in_valid && in_ready;
    for (int unsigned i = 0; i < NUM_EX_UNITS; i++) begin
      push[i] = fire && (in_instr.ex_type == EX_BITS'(i));
    end
  end

  // Stall counter and sticky misroute flag next values.
  always_comb begin
    perf_stalls_d = perf_stalls_q + PERF_CTR_BITS'(in_valid && !in_ready);
    route_err_d   = route_err_q || (fire && !route_ok);
  end

  // Perf/error state with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stalls_q <= '0;
      route_err_q   <= 1'b0;
    end else begin
      perf_stalls_q <= perf_stalls_d;
      route_err_q   <= route_err_d;
    end
  end

  assign perf_stalls = perf_stalls_q;
  assign route_err   = route_err_q;

  for (genvar g = 0; g < NUM_EX_UNITS; g++) begin : g_unit
    assign out_valid[g] = !unit_empty[g];
    assign pop[g]       = out_valid[g] && out_ready[g];

    VX_dispatch_fifo #(
      .DATAW (DATAW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push[g]),
      .pop       (pop[g]),
      .push_data (in_data),
      .full      (unit_full[g]),
      .empty     (unit_empty[g]),
      .head      (out_data[g*DATAW +: DATAW])
    );
  end

endmodule

// File: doc/vx_dispatch_route.md
VX_DISPATCH_ROUTE -- requirements
Module: VX_dispatch_route

Interface
REQ-001 SHALL have parameter NUM_EX_UNITS, default `NUM_EX_UNITS, number of execution-unit output ports.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output buffer (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid  input  1  operand-collector instruction valid (slave side of the operands handshake).
REQ-006 SHALL have port in_data  input  $bits(instr_data_t)  instruction with operands; routing uses field ex_type.
REQ-007 SHALL have port in_ready  output  1  accept for in_data.
REQ-008 SHALL have port out_valid  output  NUM_EX_UNITS  per-unit valid.
REQ-009 SHALL have port out_data  output  NUM_EX_UNITS x $bits(instr_data_t)  per-unit instruction.
REQ-010 SHALL have port out_ready  input  NUM_EX_UNITS  per-unit accept.
REQ-011 SHALL have port perf_stalls  output  PERF_CTR_BITS  cycles with in_valid=1 and in_ready=0.
REQ-012 SHALL have port route_err  output  1  sticky flag: ex_type >= NUM_EX_UNITS accepted.

Function
REQ-013 SHALL contain one FIFO per unit, DEPTH entries, count 0..DEPTH, circular read/write pointers wrapping at DEPTH.
REQ-014 SHALL assert in_ready = (ex_type < NUM_EX_UNITS) ? count[ex_type] < DEPTH : 1; no combinational path from out_ready to in_ready.
REQ-015 SHALL push in_data into FIFO[ex_type] on in_valid & in_ready (fire); at most one push per cycle.
REQ-016 SHALL drop (not push) fired instructions with ex_type >= NUM_EX_UNITS and set route_err on the next edge; route_err stays 1 until reset.
REQ-017 SHALL drive out_valid[i] = count[i] != 0 and out_data[i] = FIFO[i] head, both from registered state.
REQ-018 SHALL pop FIFO[i] on out_valid[i] & out_ready[i]; all units may pop in the same cycle.
REQ-019 SHALL give latency 1: fire into empty FIFO[i] at edge N -> out_valid[i]=1 after edge N.
REQ-020 SHALL keep count unchanged on simultaneous push and pop to the same FIFO, including when full (in_ready stays 0 that cycle per REQ-014).
REQ-021 SHALL hold out_data[i] stable while out_valid[i]=1 and out_ready[i]=0.
REQ-022 SHALL preserve order per unit; no ordering guarantee across units.
REQ-023 SHALL not block a unit's input because another unit's FIFO is full (only the addressed FIFO matters).
REQ-024 SHALL increment perf_stalls by 1 each stall cycle, wrapping modulo 2^PERF_CTR_BITS.

Reset
REQ-025 SHALL on reset_n=0 immediately clear all counts and pointers, out_valid=0, route_err=0, perf_stalls=0; FIFO storage need not reset.
REQ-026 SHALL discard in-flight buffered instructions on reset mid-operation; first fire accepted on first edge after reset_n deasserts.
REQ-027 SHALL drive in_ready per REQ-014 during reset using zero counts (no fire is recorded while reset_n=0).

Structure
REQ-028 SHALL take instr_data_t, EX_BITS, PERF_CTR_BITS from VX_gpu_pkg; no new package types.
REQ-029 SHALL instantiate one sub-module per unit: VX_dispatch_fifo (DATAW, DEPTH; push/pop/full/empty/head).
REQ-030 SHALL keep routing decode and perf/error logic in the top module.

Verification
REQ-031 SHALL test: reset, single fire ex_type=1, out_ready[1]=1 -> out_valid[1]=1 exactly one cycle after fire, out_data equal to input, other out_valid=0.
REQ-032 SHALL test: 3 fires ex_type=0 with out_ready[0]=0, DEPTH=2 -> first two accepted, in_ready=0 on third, perf_stalls increments per stall cycle; set out_ready[0]=1 -> third accepted one cycle after first pop, order A,B,C.
REQ-033 SHALL test: FIFO[0] full, alternate ex_type=2 fire -> accepted without stall (REQ-023).
REQ-034 SHALL test: fire ex_type=NUM_EX_UNITS -> no out_valid, route_err=1 next cycle and remains 1 after 10 more normal fires.
REQ-035 SHALL test: 2 entries buffered per unit, reset_n pulled low mid-cycle -> out_valid=0 immediately (asynchronous), perf_stalls=0, route_err=0.
REQ-036 SHALL test: random valid/ready stress 10k cycles against a per-unit scoreboard -> no loss, duplication or reordering; DEPTH pointer wrap exercised.
